// File: rtl/inert_fusion_integrator_pkg.sv
// Shared types, saturation-flag indices and the accel-to-angle helper for the
// gyro/accel fusion integrator.
package inert_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    RUN  = 2'd2
  } inert_state_t;

  localparam int SAT_PTCH = 0;
  localparam int SAT_ROLL = 1;
  localparam int SAT_YAW  = 2;

  // Negation is applied to the product before the >>>13, so roll rounds toward -inf
  // on the negated value, not on the magnitude.
  function automatic logic signed [15:0] accel_angle(input logic signed [15:0] avg,
                                                     input int                 gain,
                                                     input logic               negate);
    logic signed [31:0] prod;
    prod = 32'(avg) * 32'(gain);
    if (negate) prod = -prod;
    return 16'(prod >>> 13);
  endfunction

endpackage

// File: rtl/inert_fusion_integrator_sat_accum.sv
// Saturating accumulator: one signed integrator with clamp-on-overflow and a
// per-update overflow strobe (stickiness is kept by the caller).
module sat_accum #(
  parameter int W    = 27,
  parameter int IN_W = 28
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [IN_W-1:0] addend,
  output logic signed [W-1:0]    acc,
  output logic                   ovf
);

  localparam logic signed [W+1:0] MAXV = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] MINV = {3'b111, {(W-1){1'b0}}};

  logic signed [W-1:0] acc_q, acc_d;
  logic signed [W+1:0] sum_w;

  function automatic logic signed [W-1:0] clamp(input logic signed [W+1:0] s);
    if (s > MAXV) return MAXV[W-1:0];
    if (s < MINV) return MINV[W-1:0];
    return s[W-1:0];
  endfunction

  function automatic logic out_of_range(input logic signed [W+1:0] s);
    return (s > MAXV) || (s < MINV);
  endfunction

  // Two guard bits make the sum exact for any in-range accumulator plus addend.
  assign sum_w = (W+2)'(acc_q) + (W+2)'(addend);

  always_comb begin
    acc_d = acc_q;
    ovf   = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = clamp(sum_w);
      ovf   = out_of_range(sum_w);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/inert_fusion_integrator.sv
// Gyro offset calibration plus complementary-filter integration of pitch/roll/yaw,
// with pitch/roll leaking toward the windowed-average accel angles.
module inert_fusion_integrator
  import inert_pkg::*;
#(
  parameter int CAL_LOG2  = 11,
  parameter int AVG_LOG2  = 4,
  parameter int INT_W     = 27,
  parameter int OUT_SHIFT = 13,
  parameter int LEAK      = 2048,
  parameter int G_SCALE   = 327
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               strt_cal,
  input  logic               zero_yaw,
  input  logic               vld,
  input  logic signed [15:0] ptch_rt,
  input  logic signed [15:0] roll_rt,
  input  logic signed [15:0] yaw_rt,
  input  logic signed [15:0] ax,
  input  logic signed [15:0] ay,
  output logic               cal_done,
  output logic               cal_busy,
  output logic signed [15:0] ptch,
  output logic signed [15:0] roll,
  output logic signed [15:0] yaw,
  output logic [2:0]         sat
);

  localparam int ADD_W = INT_W + 1;
  localparam int CNT_W = CAL_LOG2 + 1;
  localparam int ACC_W = 16 + AVG_LOG2;
  localparam logic [CNT_W-1:0]        CAL_N  = {1'b1, {CAL_LOG2{1'b0}}};
  localparam logic signed [ADD_W-1:0] LEAK_P = ADD_W'(LEAK);
  localparam logic signed [ADD_W-1:0] LEAK_N = ADD_W'(-LEAK);

  inert_state_t state_q, state_d;
  logic [CNT_W-1:0] cal_cnt_q, cal_cnt_d;
  logic signed [15:0] off_ptch_q, off_roll_q, off_yaw_q;
  logic signed [15:0] off_ptch_d, off_roll_d, off_yaw_d;
  logic [2:0] sat_q, sat_d;

  logic [AVG_LOG2-1:0] win_q, win_d;
  logic signed [ACC_W-1:0] ax_acc_q, ay_acc_q, ax_acc_d, ay_acc_d;
  logic signed [ACC_W-1:0] ax_sum, ay_sum;
  logic signed [15:0] ax_avg_q, ay_avg_q, ax_avg_d, ay_avg_d;

  logic clr_pr, clr_yaw_only, en_int, load_off, clr_sat, done_c;
  logic signed [INT_W-1:0] ptch_int, roll_int, yaw_int;
  logic ovf_ptch, ovf_roll, ovf_yaw;
  logic signed [16:0] d_ptch, d_roll, d_yaw;
  logic signed [ADD_W-1:0] fus_p, fus_r;
  logic signed [ADD_W-1:0] add_ptch, add_roll, add_yaw;
  logic signed [15:0] ptch_g, roll_g;

  // Control: calibration sequencing and integrator clear/enable decode.
  always_comb begin
    state_d      = state_q;
    cal_cnt_d    = cal_cnt_q;
    clr_pr       = 1'b0;
    clr_yaw_only = 1'b0;
    en_int       = 1'b0;
    load_off     = 1'b0;
    clr_sat      = 1'b0;
    done_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (strt_cal) begin
          state_d   = CAL;
          cal_cnt_d = '0;
          clr_pr    = 1'b1;
          clr_sat   = 1'b1;
        end
      end
      CAL: begin
        if (strt_cal) begin
          cal_cnt_d = '0;
          clr_pr    = 1'b1;
          clr_sat   = 1'b1;
        end else if (cal_cnt_q == CAL_N) begin
          done_c    = 1'b1;
          load_off  = 1'b1;
          clr_pr    = 1'b1;
          cal_cnt_d = '0;
          state_d   = RUN;
        end else if (vld) begin
          en_int    = 1'b1;
          cal_cnt_d = cal_cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (strt_cal) begin
          state_d   = CAL;
          cal_cnt_d = '0;
          clr_pr    = 1'b1;
          clr_sat   = 1'b1;
        end else begin
          en_int       = vld;
          clr_yaw_only = zero_yaw;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Offsets are the calibration sum divided by the sample count (floor).
  always_comb begin
    off_ptch_d = off_ptch_q;
    off_roll_d = off_roll_q;
    off_yaw_d  = off_yaw_q;
    if (load_off) begin
      off_ptch_d = ptch_int[CAL_LOG2+15:CAL_LOG2];
      off_roll_d = roll_int[CAL_LOG2+15:CAL_LOG2];
      off_yaw_d  = yaw_int[CAL_LOG2+15:CAL_LOG2];
    end
  end

  assign sat_d = clr_sat ? 3'b000 : (sat_q | {ovf_yaw, ovf_roll, ovf_ptch});

  // Accel window: the all-ones vld folds its own sample into the average.
  assign ax_sum = ax_acc_q + ACC_W'(ax);
  assign ay_sum = ay_acc_q + ACC_W'(ay);

  always_comb begin
    win_d    = win_q;
    ax_acc_d = ax_acc_q;
    ay_acc_d = ay_acc_q;
    ax_avg_d = ax_avg_q;
    ay_avg_d = ay_avg_q;
    if (vld) begin
      win_d = win_q + AVG_LOG2'(1);
      if (&win_q) begin
        ax_avg_d = 16'(ax_sum >>> AVG_LOG2);
        ay_avg_d = 16'(ay_sum >>> AVG_LOG2);
        ax_acc_d = '0;
        ay_acc_d = '0;
      end else begin
        ax_acc_d = ax_sum;
        ay_acc_d = ay_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cal_cnt_q  <= '0;
      off_ptch_q <= '0;
      off_roll_q <= '0;
      off_yaw_q  <= '0;
      sat_q      <= '0;
      win_q      <= '0;
      ax_acc_q   <= '0;
      ay_acc_q   <= '0;
      ax_avg_q   <= '0;
      ay_avg_q   <= '0;
    end else begin
      state_q    <= state_d;
      cal_cnt_q  <= cal_cnt_d;
      off_ptch_q <= off_ptch_d;
      off_roll_q <= off_roll_d;
      off_yaw_q  <= off_yaw_d;
      sat_q      <= sat_d;
      win_q      <= win_d;
      ax_acc_q   <= ax_acc_d;
      ay_acc_q   <= ay_acc_d;
      ax_avg_q   <= ax_avg_d;
      ay_avg_q   <= ay_avg_d;
    end
  end

  assign ptch_g = accel_angle(ay_avg_q, G_SCALE, 1'b0);
  assign roll_g = accel_angle(ax_avg_q, G_SCALE, 1'b1);

  // Integrator addends: raw rate during CAL, offset-compensated rate plus leak in RUN.
  always_comb begin
    d_ptch = 17'(ptch_rt);
    d_roll = 17'(roll_rt);
    d_yaw  = 17'(yaw_rt);
    fus_p  = '0;
    fus_r  = '0;
    if (state_q == RUN) begin
      d_ptch = 17'(ptch_rt) - 17'(off_ptch_q);
      d_roll = 17'(roll_rt) - 17'(off_roll_q);
      d_yaw  = 17'(yaw_rt) - 17'(off_yaw_q);
      fus_p  = (ptch_g > ptch) ? LEAK_P : LEAK_N;
      fus_r  = (roll_g > roll) ? LEAK_P : LEAK_N;
    end
    add_ptch = ADD_W'(d_ptch) + fus_p;
    add_roll = ADD_W'(d_roll) + fus_r;
    add_yaw  = ADD_W'(d_yaw);
  end

  sat_accum #(.W(INT_W), .IN_W(ADD_W)) u_ptch (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_pr),
    .en     (en_int),
    .addend (add_ptch),
    .acc    (ptch_int),
    .ovf    (ovf_ptch)
  );

  sat_accum #(.W(INT_W), .IN_W(ADD_W)) u_roll (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_pr),
    .en     (en_int),
    .addend (add_roll),
    .acc    (roll_int),
    .ovf    (ovf_roll)
  );

  sat_accum #(.W(INT_W), .IN_W(ADD_W)) u_yaw (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_pr | clr_yaw_only),
    .en     (en_int),
    .addend (add_yaw),
    .acc    (yaw_int),
    .ovf    (ovf_yaw)
  );

  assign ptch     = 16'(ptch_int >>> OUT_SHIFT);
  assign roll     = 16'(roll_int >>> OUT_SHIFT);
  assign yaw      = 16'(yaw_int >>> OUT_SHIFT);
  assign cal_done = done_c;
  assign cal_busy = (state_q == CAL);
  assign sat      = sat_q;

endmodule
